// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the front-end blocks.
//   fetch_state_t     - fetch controller state encoding
//   NOP_INSTR         - canonical NOP (addi x0, x0, 0)
//   DEFAULT_RESET_PC  - default first fetch address after reset
package riscv_pkg;

    typedef enum logic [1:0] {
        START   = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding-request instruction fetch stage.
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   pc_sel, target redirect request and its address (low two bits ignored)
//   imem_req       instruction-memory request
//   imem_addr      instruction-memory address, stable until imem_ack
//   imem_ack       memory accepted the request, imem_rdata valid this cycle
//   imem_rdata     instruction word
//   out_valid      instruction available to decode
//   out_ready      decode accepts the instruction
//   out_instr      fetched instruction
//   out_pc         address of out_instr
//   out_pc4        out_pc + 4 (link value)
//   dbg_state      current controller state, for observation only
//
// Handshakes: the memory side is request/acknowledge -- imem_req is held
// with a stable imem_addr until a cycle with imem_ack=1, which completes
// the transfer. The decode side is valid/ready -- out_valid stays high with
// stable payload until a cycle where out_valid & out_ready, which delivers.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_sel,
    input  logic [WIDTH-1:0] target,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_pc4,
    output logic [1:0]       dbg_state
);

    fetch_state_t     state, state_next;
    logic [WIDTH-1:0] pc, pc_next;
    logic [WIDTH-1:0] redirect_pc, redirect_next;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] tgt;
    logic             capture;
    logic             valid_next;

    // Word-aligned redirect address; plain addition wraps modulo 2^WIDTH.
    assign tgt       = target & ~(WIDTH'(3));
    assign pc_inc    = pc + WIDTH'(4);
    assign imem_addr = pc;
    assign dbg_state = state;

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        redirect_next = redirect_pc;
        capture       = 1'b0;
        valid_next    = out_valid;
        imem_req      = 1'b0;

        case (state)
            START: begin
                state_next = FETCH;
                if (pc_sel) pc_next = tgt;
            end

            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (pc_sel) begin
                        // Returned word belongs to the wrong path: drop it.
                        pc_next = tgt;
                    end else begin
                        capture    = 1'b1;
                        pc_next    = pc_inc;
                        valid_next = 1'b1;
                        state_next = HOLD;
                    end
                end else if (pc_sel) begin
                    // The request cannot be withdrawn; keep presenting the
                    // old address and remember where to go once it lands.
                    redirect_next = tgt;
                    state_next    = DISCARD;
                end
            end

            DISCARD: begin
                imem_req = 1'b1;
                if (pc_sel) redirect_next = tgt;
                if (imem_ack) begin
                    pc_next    = pc_sel ? tgt : redirect_pc;
                    state_next = FETCH;
                end
            end

            HOLD: begin
                // A handshake coinciding with a redirect still delivers;
                // either event ends the hold. pc already points past out_pc.
                if (pc_sel || out_ready) begin
                    valid_next = 1'b0;
                    state_next = FETCH;
                    if (pc_sel) pc_next = tgt;
                end
            end

            default: begin
                state_next = START;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= START;
            pc          <= RESET_PC;
            redirect_pc <= RESET_PC;
            out_valid   <= 1'b0;
            out_instr   <= NOP_INSTR;
            out_pc      <= '0;
            out_pc4     <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            redirect_pc <= redirect_next;
            out_valid   <= valid_next;
            if (capture) begin
                out_instr <= imem_rdata;
                out_pc    <= pc;
                out_pc4   <= pc_inc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import riscv_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT 0 (RESET_PC = 0) ----------------
    logic        pc_sel, imem_ack, out_ready;
    logic [31:0] target;
    logic        imem_req, out_valid;
    logic [31:0] imem_addr, imem_rdata, out_instr, out_pc, out_pc4;
    logic [1:0]  dbg_state;

    // ---------------- DUT 1 (RESET_PC = 0xFFFF_FFFC) ----------------
    logic        pc_sel1, imem_ack1, out_ready1;
    logic [31:0] target1;
    logic        imem_req1, out_valid1;
    logic [31:0] imem_addr1, imem_rdata1, out_instr1, out_pc1, out_pc41;
    logic [1:0]  dbg_state1;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    assign imem_rdata  = mem_word(imem_addr);
    assign imem_rdata1 = mem_word(imem_addr1);

    fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) u0 (
        .clk(clk), .rst(rst), .pc_sel(pc_sel), .target(target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_pc4(out_pc4),
        .dbg_state(dbg_state)
    );

    fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u1 (
        .clk(clk), .rst(rst), .pc_sel(pc_sel1), .target(target1),
        .imem_req(imem_req1), .imem_addr(imem_addr1), .imem_ack(imem_ack1),
        .imem_rdata(imem_rdata1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_instr(out_instr1), .out_pc(out_pc1), .out_pc4(out_pc41),
        .dbg_state(dbg_state1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic sel, input logic [31:0] tgt, input logic ack, input logic rdy);
        pc_sel    = sel;
        target    = tgt;
        imem_ack  = ack;
        out_ready = rdy;
    endtask

    // Holds reset for two edges, checks reset values, releases #1 after an edge.
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   32'(imem_req),  32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr,      NOP_INSTR);
        check("rst_pc",    out_pc,         32'd0);
        check("rst_pc4",   out_pc4,        32'd0);
        check("rst_state", 32'(dbg_state), 32'(START));
        check("rst_req1",  32'(imem_req1), 32'd0);
        rst = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        sel;
        logic [31:0] tgt;
        logic        ack;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt[21];

    function automatic vec_t mk(input logic sel, input logic [31:0] tgt, input logic ack,
                                input logic rdy, input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc);
        vec_t v;
        v.sel = sel; v.tgt = tgt; v.ack = ack; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    // ---------------- behavioural reference model ----------------
    // Described as the fetch stage's obligations: is it waiting out reset,
    // is an instruction waiting for decode, is a memory access outstanding,
    // and if so, will its data be thrown away.
    logic        m_in_start, m_have_out, m_requesting, m_doomed;
    logic [31:0] m_pc, m_redir;
    logic [31:0] m_out_pc, m_out_instr;
    logic [31:0] exp_q[$];   // addresses delivered to decode, in order
    logic [31:0] got_q[$];

    task automatic model_reset();
        m_in_start = 1'b1; m_have_out = 1'b0; m_requesting = 1'b0; m_doomed = 1'b0;
        m_pc = 32'h0; m_redir = 32'h0; m_out_pc = 32'h0; m_out_instr = NOP_INSTR;
    endtask

    task automatic model_step(input logic sel, input logic [31:0] tgt_raw, input logic ack,
                              input logic rdy);
        logic [31:0] tgt;
        tgt = {tgt_raw[31:2], 2'b00};
        if (m_in_start) begin
            if (sel) m_pc = tgt;
            m_in_start   = 1'b0;
            m_requesting = 1'b1;
        end else if (m_have_out) begin
            if (rdy) exp_q.push_back(m_out_pc);
            if (sel || rdy) begin
                m_have_out   = 1'b0;
                m_requesting = 1'b1;
                if (sel) m_pc = tgt;
            end
        end else if (m_requesting && !m_doomed) begin
            if (ack && sel) begin
                m_pc = tgt;
            end else if (ack) begin
                m_out_pc     = m_pc;
                m_out_instr  = mem_word(m_pc);
                m_pc         = m_pc + 32'd4;
                m_have_out   = 1'b1;
                m_requesting = 1'b0;
            end else if (sel) begin
                m_doomed = 1'b1;
                m_redir  = tgt;
            end
        end else if (m_requesting) begin
            if (sel) m_redir = tgt;
            if (ack) begin
                m_pc     = m_redir;
                m_doomed = 1'b0;
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        pc_sel1 = 1'b0; target1 = 32'h0; imem_ack1 = 1'b1; out_ready1 = 1'b1;

        vt[0]  = mk(0, 32'h000, 1, 1, 0, 32'h000, 0, 32'h000);
        vt[1]  = mk(0, 32'h000, 1, 1, 1, 32'h000, 0, 32'h000);
        vt[2]  = mk(0, 32'h000, 1, 1, 0, 32'h000, 1, 32'h000);
        vt[3]  = mk(0, 32'h000, 1, 1, 1, 32'h004, 0, 32'h000);
        vt[4]  = mk(0, 32'h000, 1, 1, 0, 32'h000, 1, 32'h004);
        vt[5]  = mk(1, 32'h100, 0, 1, 1, 32'h008, 0, 32'h000);
        vt[6]  = mk(0, 32'h000, 0, 1, 1, 32'h008, 0, 32'h000);
        vt[7]  = mk(0, 32'h000, 1, 1, 1, 32'h008, 0, 32'h000);
        vt[8]  = mk(0, 32'h000, 1, 1, 1, 32'h100, 0, 32'h000);
        vt[9]  = mk(0, 32'h000, 1, 0, 0, 32'h000, 1, 32'h100);
        vt[10] = mk(0, 32'h000, 1, 0, 0, 32'h000, 1, 32'h100);
        vt[11] = mk(0, 32'h000, 1, 0, 0, 32'h000, 1, 32'h100);
        vt[12] = mk(0, 32'h000, 1, 0, 0, 32'h000, 1, 32'h100);
        vt[13] = mk(0, 32'h000, 1, 0, 0, 32'h000, 1, 32'h100);
        vt[14] = mk(1, 32'h203, 1, 0, 0, 32'h000, 1, 32'h100);
        vt[15] = mk(0, 32'h000, 0, 1, 1, 32'h200, 0, 32'h000);
        vt[16] = mk(0, 32'h000, 1, 1, 1, 32'h200, 0, 32'h000);
        vt[17] = mk(1, 32'h300, 1, 1, 0, 32'h000, 1, 32'h200);
        vt[18] = mk(1, 32'h400, 1, 1, 1, 32'h300, 0, 32'h000);
        vt[19] = mk(0, 32'h000, 1, 1, 1, 32'h400, 0, 32'h000);
        vt[20] = mk(0, 32'h000, 1, 1, 0, 32'h000, 1, 32'h400);

        // ---- table-driven directed run (both instances) ----
        do_reset();
        for (int i = 0; i < 21; i++) begin
            drive(vt[i].sel, vt[i].tgt, vt[i].ack, vt[i].rdy);
            check($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vt[i].e_req));
            if (vt[i].e_req)
                check($sformatf("vec%0d_addr", i), imem_addr, vt[i].e_addr);
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].e_valid));
            if (vt[i].e_valid) begin
                check($sformatf("vec%0d_pc", i), out_pc, vt[i].e_pc);
                check($sformatf("vec%0d_pc4", i), out_pc4, vt[i].e_pc + 32'd4);
                check($sformatf("vec%0d_instr", i), out_instr, mem_word(vt[i].e_pc));
            end
            if (i == 0) check("wrap_start_req", 32'(imem_req1), 32'd0);
            if (i == 1) check("wrap_first_addr", imem_addr1, 32'hFFFF_FFFC);
            if (i == 2) begin
                check("wrap_first_pc", out_pc1, 32'hFFFF_FFFC);
                check("wrap_first_pc4", out_pc41, 32'h0000_0000);
            end
            if (i == 3) check("wrap_second_addr", imem_addr1, 32'h0000_0000);
            @(posedge clk);
            #1;
        end

        // ---- reset while a request waits for ack ----
        do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        @(posedge clk); #1;                       // now FETCH, no ack yet
        check("midrst_pre_req", 32'(imem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_req_async", 32'(imem_req), 32'd0);
        imem_ack = 1'b1;                          // stale ack must be ignored
        @(posedge clk); #1;
        rst = 1'b0;                               // START cycle after release
        check("midrst_start_req", 32'(imem_req), 32'd0);
        check("midrst_start_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("midrst_fetch_req", 32'(imem_req), 32'd1);
        check("midrst_fetch_addr", imem_addr, 32'h0);
        check("midrst_fetch_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("midrst_deliver_valid", 32'(out_valid), 32'd1);
        check("midrst_deliver_pc", out_pc, 32'h0);

        // ---- randomized run against the reference model ----
        do_reset();
        model_reset();
        exp_q.delete();
        got_q.delete();
        for (int c = 0; c < 4000; c++) begin
            logic        r_sel, r_ack, r_rdy;
            logic [31:0] r_tgt;
            check("rnd_req", 32'(imem_req), 32'(m_requesting));
            if (m_requesting) check("rnd_addr", imem_addr, m_pc);
            check("rnd_valid", 32'(out_valid), 32'(m_have_out));
            if (m_have_out) begin
                check("rnd_pc", out_pc, m_out_pc);
                check("rnd_pc4", out_pc4, m_out_pc + 32'd4);
                check("rnd_instr", out_instr, m_out_instr);
            end
            r_sel = ($urandom_range(0, 7) == 0);
            r_tgt = $urandom();
            if ($urandom_range(0, 15) == 0) r_tgt = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            r_ack = ($urandom_range(0, 1) == 1);
            r_rdy = ($urandom_range(0, 9) < 6);
            drive(r_sel, r_tgt, r_ack, r_rdy);
            if (out_valid && out_ready) got_q.push_back(out_pc);
            @(posedge clk);
            model_step(r_sel, r_tgt, r_ack, r_rdy);
            #1;
        end

        // ---- scoreboard: delivered stream ----
        check("sb_count", 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [31:0] e, g;
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check("sb_pc", g, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, address/PC width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  clock, rising edge; rst  input  1  reset.
REQ-004 pc_sel  input  1  redirect request from the branch controller, sampled every cycle.
REQ-005 target  input  WIDTH  redirect address, valid when pc_sel=1.
REQ-006 imem_req  output  1  instruction-memory request.
REQ-007 imem_addr  output  WIDTH  instruction-memory address.
REQ-008 imem_ack  input  1  memory accepted the request and returns data this cycle.
REQ-009 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-010 out_valid  output  1  instruction available to decode.
REQ-011 out_ready  input  1  decode accepts the instruction.
REQ-012 out_instr  output  32  fetched instruction.
REQ-013 out_pc  output  WIDTH  address of out_instr.
REQ-014 out_pc4  output  WIDTH  out_pc+4, the JAL/JALR link value.

Function
REQ-015 SHALL implement states START, FETCH, HOLD, DISCARD.
REQ-016 START: imem_req=0; next state FETCH unconditionally.
REQ-017 FETCH and DISCARD: imem_req=1 and imem_addr=pc; imem_addr SHALL stay stable until imem_ack.
REQ-018 HOLD and START: imem_req=0.
REQ-019 FETCH, imem_ack=1, pc_sel=0: capture imem_rdata and pc into the output registers; pc<=pc+4; out_valid=1 from the next cycle; next state HOLD.
REQ-020 Ack latency is unbounded; an ack in the same cycle as the request is legal.
REQ-021 HOLD: output registers SHALL stay stable until out_valid&out_ready; on that handshake, out_valid=0 next cycle and next state FETCH.
REQ-022 Minimum spacing between deliveries SHALL be 2 cycles.
REQ-023 pc_sel=1 in HOLD: out_valid=0 next cycle; pc<=target; next state FETCH.
REQ-024 A handshake completing in the same cycle as pc_sel=1 SHALL count as delivered.
REQ-025 pc_sel=1 in FETCH with imem_ack=1: discard imem_rdata; pc<=target; remain FETCH.
REQ-026 pc_sel=1 in FETCH with imem_ack=0: store target in redirect_pc; keep the old imem_addr; next state DISCARD.
REQ-027 DISCARD with pc_sel=1: overwrite redirect_pc with the newer target.
REQ-028 DISCARD with imem_ack=1: discard data; pc<=redirect_pc (or target if pc_sel=1 in the same cycle); next state FETCH.
REQ-029 pc_sel in START SHALL load pc<=target.
REQ-030 target[1:0] SHALL be forced to 2'b00 when loaded.
REQ-031 pc+4 and out_pc4 SHALL wrap modulo 2^WIDTH (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-032 out_valid SHALL never be 1 for a discarded fetch.

Reset
REQ-033 rst=1 SHALL asynchronously set: state=START, pc=RESET_PC, redirect_pc=RESET_PC, out_valid=0, out_instr=32'h0000_0013 (NOP), out_pc=0, out_pc4=0.
REQ-034 imem_req SHALL be 0 while rst=1 and in the first cycle after release.
REQ-035 Reset during an outstanding request SHALL abandon it; any ack arriving before FETCH is re-entered SHALL be ignored.

Structure
REQ-036 fetch_state_t, the NOP constant and the default RESET_PC SHALL live in the shared package riscv_pkg.
REQ-037 No sub-module SHALL be used; the pc+4 incrementers are inline.

Verification
REQ-038 Reset release with ack tied high, out_ready=1: fetches at 0x0, 0x4, 0x8; out_valid every other cycle; out_pc4=0x4, 0x8, 0xC.
REQ-039 HOLD with out_ready=0 for 5 cycles: out_instr/out_pc stable; imem_req=0 throughout.
REQ-040 pc_sel=1, target=0x100, while the request to 0x8 awaits ack (3-cycle latency): imem_addr stays 0x8 until ack; data dropped; next request at 0x100; out_valid never shows 0x8.
REQ-041 pc_sel=1 in HOLD with target=0x203: out_valid drops next cycle; next imem_addr=0x200.
REQ-042 RESET_PC=32'hFFFF_FFFC: first out_pc4=0x0; second fetch at 0x0.
REQ-043 rst asserted mid-wait with imem_ack=0, then deasserted: START one cycle; first request at RESET_PC.
